// File: rtl/bpu_update_sched_pkg.sv
// Shared types and constants for the BPU update scheduler slice.
package bpu_update_sched_pkg;

  localparam int BPU_UPD_QDEPTH = 8;
  localparam int BPU_BTB_LEN    = 9;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } bpu_upd_state_e;

  typedef struct packed {
    logic        update;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  br_type;
  } correct_info_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// Two-write/one-read register FIFO; wr_num entries land at tail, tail+1 in order.
// Caller guarantees wr_num never exceeds free space and rd_en only when count != 0.
module bpu_upd_fifo
  import bpu_update_sched_pkg::*;
#(
  parameter int DEPTH = BPU_UPD_QDEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [1:0]                 wr_num,
  input  correct_info_t              wr0_dat,
  input  correct_info_t              wr1_dat,
  input  logic                       rd_en,
  output correct_info_t              rd_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  correct_info_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_num);
      rd_ptr <= rd_ptr + PW'(rd_en);
      count  <= count + CW'(wr_num) - CW'(rd_en);
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && wr_num != 2'd0) mem[wr_ptr] <= wr0_dat;
    if (rst_n && !clr && wr_num == 2'd2) mem[wr_ptr + 1'b1] <= wr1_dat;
  end

  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/bpu_update_sched.sv
// Queues up to two corrections per cycle, issues one BPU update per cycle, and sweeps tables after reset/reinit.
// Optional perf counters enabled by defining BPU_UPD_PERF_EN.
module bpu_update_sched
  import bpu_update_sched_pkg::*;
#(
  parameter int QUEUE_DEPTH = BPU_UPD_QDEPTH,
  parameter int IDX_LEN     = BPU_BTB_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  correct_info_t [1:0]          req_i,
  input  logic                         reinit_i,
  output correct_info_t                upd_o,
  output logic                         upd_valid_o,
  input  logic                         upd_ready_i,
  output logic                         init_we_o,
  output logic [IDX_LEN-1:0]           init_idx_o,
  output logic                         busy_o,
  output logic [$clog2(QUEUE_DEPTH):0] q_count_o,
  output logic [31:0]                  enq_cnt_o,
  output logic [31:0]                  drop_cnt_o
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  bpu_upd_state_e     state_q, state_d;
  logic [IDX_LEN-1:0] idx_q, idx_d;

  logic          v0, v1;
  logic [CW-1:0] q_free;
  logic [1:0]    wr_num;
  logic [1:0]    n_drop;
  correct_info_t wr0_dat;

  assign v0     = req_i[0].update;
  assign v1     = req_i[1].update;
  // Free space comes from the registered count; a same-cycle pop does not help.
  assign q_free = CW'(QUEUE_DEPTH) - q_count_o;

  always_comb begin
    wr_num  = 2'd0;
    n_drop  = 2'd0;
    wr0_dat = req_i[0];
    if (reinit_i) begin
      n_drop = {1'b0, v0} + {1'b0, v1};
    end else if (v0 && v1) begin
      if (q_free >= CW'(2)) begin
        wr_num = 2'd2;
      end else if (q_free == CW'(1)) begin
        wr_num = 2'd1;
        n_drop = 2'd1;
      end else begin
        n_drop = 2'd2;
      end
    end else if (v0 || v1) begin
      wr0_dat = v0 ? req_i[0] : req_i[1];
      if (q_free != '0) wr_num = 2'd1;
      else              n_drop = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_we_o   = 1'b0;
    busy_o      = 1'b0;
    upd_valid_o = 1'b0;
    case (state_q)
      S_INIT: begin
        init_we_o = 1'b1;
        busy_o    = 1'b1;
        idx_d     = idx_q + 1'b1;
        if (idx_q == {IDX_LEN{1'b1}}) state_d = S_RUN;
      end
      S_RUN: begin
        upd_valid_o = (q_count_o != '0);
      end
    endcase
    if (reinit_i) begin
      state_d = S_INIT;
      idx_d   = '0;
    end
  end

  assign init_idx_o = idx_q;

  bpu_upd_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (reinit_i),
    .wr_num  (wr_num),
    .wr0_dat (wr0_dat),
    .wr1_dat (req_i[1]),
    .rd_en   (upd_valid_o & upd_ready_i),
    .rd_dat  (upd_o),
    .count   (q_count_o)
  );

`ifdef BPU_UPD_PERF_EN
  logic [31:0] enq_q, drop_q;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enq_q  <= '0;
      drop_q <= '0;
    end else begin
      enq_q  <= sat_add(enq_q, wr_num);
      drop_q <= sat_add(drop_q, n_drop);
    end
  end

  assign enq_cnt_o  = enq_q;
  assign drop_cnt_o = drop_q;
`else
  logic unused_perf;
  assign unused_perf = ^n_drop;
  assign enq_cnt_o   = '0;
  assign drop_cnt_o  = '0;
`endif

endmodule
